// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame length and the receiver/initiator state encoding.
package spi_pkg;

  localparam int FRAME_BITS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } spi_state_e;

  // Width needed to count 0..bits inclusive.
  function automatic int cnt_width(input int bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with registered rise/fall events.
// level is delayed one stage past the synchronizer so it lines up with rise/fall.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic ff1;
  logic ff2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff1   <= RST_VAL;
      ff2   <= RST_VAL;
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      ff1   <= din;
      ff2   <= ff1;
      level <= ff2;
      rise  <= ff2 & ~level;
      fall  <= ~ff2 & level;
    end
  end

endmodule

// File: rtl/spi_frame_rx.sv
// SPI target receiver: oversampled ss_n/sck/mosi, 16-bit word assembly, valid/ack output.
// Optional MISO readback of the last accepted word when SPI_FRAME_RX_MISO_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for ss_n to fall; bit count held at 0
//   SHIFT | collecting bits on sck rising edges
//   FULL  | all frame bits received; any further sck edge marks the frame as long
module spi_frame_rx
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss_n,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  frame_err,
  output logic                  overflow,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(FRAME_BITS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);

  logic ss_lvl, ss_rise, ss_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk   (clk),
    .rst   (rst),
    .din   (ss_n),
    .level (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .rst   (rst),
    .din   (sck),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (mosi),
    .level (mosi_s),
    .rise  (mosi_rise),
    .fall  (mosi_fall)
  );

  // A select already low when reset lifts must not start a frame: wait for the
  // synchronizer to flush, then require ss_n to be seen high before arming.
  logic [1:0] flush_cnt;
  logic       armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= 2'd0;
      armed     <= 1'b0;
    end else begin
      if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
      if (flush_cnt == 2'd3 && ss_lvl) armed <= 1'b1;
    end
  end

  spi_state_e            state, state_nxt;
  logic [CNT_W-1:0]      bit_cnt, cnt_nxt;
  logic [FRAME_BITS-1:0] shift_reg, shift_nxt;
  logic                  long_flag, long_nxt;
  logic                  deliver, err_nxt;
  logic                  frame_start;

  assign frame_start = (state == IDLE) && ss_fall && armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      long_flag <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= cnt_nxt;
      shift_reg <= shift_nxt;
      long_flag <= long_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    long_nxt  = long_flag;
    deliver   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        long_nxt = 1'b0;
        if (frame_start) begin
          state_nxt = SHIFT;
          shift_nxt = '0;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          shift_nxt = {shift_reg[FRAME_BITS-2:0], mosi_s};
          cnt_nxt   = bit_cnt + CNT_W'(1);
        end
        // End of frame is judged on the count including a coincident sample.
        if (ss_rise) begin
          state_nxt = IDLE;
          if (cnt_nxt == FULL_CNT) deliver = 1'b1;
          else                     err_nxt = 1'b1;
        end else if (cnt_nxt == FULL_CNT) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (sck_rise) long_nxt = 1'b1;
        if (ss_rise) begin
          state_nxt = IDLE;
          if (long_nxt) err_nxt = 1'b1;
          else          deliver = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A delivery while a word is pending drops the new word; a same-cycle ack
  // still retires the pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= err_nxt;
      overflow  <= deliver & rx_valid;
      if (deliver && !rx_valid) begin
        rx_data  <= shift_nxt;
        rx_valid <= 1'b1;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef SPI_FRAME_RX_MISO_EN
  logic [FRAME_BITS-1:0] tx_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= '0;
    end else if (frame_start) begin
      tx_shift <= rx_data;
    end else if (state == SHIFT && sck_fall) begin
      tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign miso = (state != IDLE) & tx_shift[FRAME_BITS-1];

  logic unused_edges;
  assign unused_edges = ^{sck_lvl, mosi_rise, mosi_fall};
`else
  assign miso = 1'b0;

  logic unused_edges;
  assign unused_edges = ^{sck_lvl, sck_fall, mosi_rise, mosi_fall};
`endif

endmodule
